// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display: segment codes,
// digit-slot indices, time limits and the scan FSM state type.
package seg_pkg;

    // Active-low segment patterns, bit order a b c d e f g (dp excluded)
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    localparam logic [1:0] HT = 2'd0;
    localparam logic [1:0] HU = 2'd1;
    localparam logic [1:0] MT = 2'd2;
    localparam logic [1:0] MU = 2'd3;

    localparam int HOURS_MAX   = 23;
    localparam int MINUTES_MAX = 59;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } scan_state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Pure combinational decode of a 7-bit active-low segment pattern to a BCD
// digit; anything that is not one of the ten digit glyphs is flagged invalid.
module seg7_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        case (pattern)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of the HH:MM multiplexed display: waits for each digit dwell to
// settle, decodes it into its slot and publishes range-checked complete frames.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] out,
    input  logic [7:0] seg,
    output logic [1:0] hh_t,
    output logic [3:0] hh_u,
    output logic [2:0] mm_t,
    output logic [3:0] mm_u,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       scan_lost
);

    localparam int               TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX     = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    logic [3:0]       out_m, out_s, out_p;
    logic [7:0]       seg_m, seg_s, seg_p;
    logic             in_stable;
    logic             out_onehot;

    scan_state_t      state, state_next;
    logic [7:0]       stable_cnt, stable_next;
    logic             capture;

    logic [3:0]       dec_digit;
    logic             dec_valid;
    logic [1:0]       slot_idx;
    logic [3:0]       slot_digit [4];
    logic [3:0]       slot_valid;
    logic [3:0]       mask;
    logic [TMO_W-1:0] tmo_cnt;

    logic [6:0]       hours;
    logic [6:0]       minutes;
    logic             frame_legal;

    // Two-flop synchronisers plus one more stage for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_m <= '0;
            out_s <= '0;
            out_p <= '0;
            seg_m <= '0;
            seg_s <= '0;
            seg_p <= '0;
        end else begin
            out_m <= out;
            out_s <= out_m;
            out_p <= out_s;
            seg_m <= seg;
            seg_s <= seg_m;
            seg_p <= seg_s;
        end
    end

    assign in_stable  = (out_s == out_p) && (seg_s == seg_p);
    assign out_onehot = (out_s != 4'b0000) && ((out_s & (out_s - 4'd1)) == 4'b0000);

    seg7_to_bcd u_dec (
        .pattern (seg_s[7:1]),
        .digit   (dec_digit),
        .valid   (dec_valid)
    );

    always_comb begin
        case (out_s)
            4'b0001: slot_idx = HT;
            4'b0010: slot_idx = HU;
            4'b0100: slot_idx = MT;
            default: slot_idx = MU;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            stable_cnt <= '0;
        end else begin
            state      <= state_next;
            stable_cnt <= stable_next;
        end
    end

    // One capture per dwell; any input change in HOLD forces a fresh settle
    always_comb begin
        state_next  = state;
        stable_next = stable_cnt;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                stable_next = '0;
                if (out_onehot) state_next = SETTLE;
            end
            SETTLE: begin
                if (!out_onehot) begin
                    state_next  = IDLE;
                    stable_next = '0;
                end else if (!in_stable) begin
                    stable_next = '0;
                end else if (stable_cnt == SETTLE_LAST) begin
                    capture     = 1'b1;
                    state_next  = HOLD;
                    stable_next = '0;
                end else begin
                    stable_next = stable_cnt + 8'd1;
                end
            end
            HOLD: begin
                stable_next = '0;
                if (!out_onehot)     state_next = IDLE;
                else if (!in_stable) state_next = SETTLE;
            end
            default: begin
                state_next  = IDLE;
                stable_next = '0;
            end
        endcase
    end

    assign hours   = 7'(slot_digit[HT]) * 7'd10 + 7'(slot_digit[HU]);
    assign minutes = 7'(slot_digit[MT]) * 7'd10 + 7'(slot_digit[MU]);

    assign frame_legal = (slot_valid == 4'b1111)
                      && (slot_digit[HT] <= 4'd2)
                      && (hours <= 7'(HOURS_MAX))
                      && (slot_digit[MT] <= 4'd5)
                      && (minutes <= 7'(MINUTES_MAX));

    assign scan_lost = (tmo_cnt == TMO_MAX);

    // A full mask is judged one cycle after the last capture, then emptied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) slot_digit[i] <= '0;
            slot_valid  <= '0;
            mask        <= '0;
            tmo_cnt     <= '0;
            hh_t        <= '0;
            hh_u        <= '0;
            mm_t        <= '0;
            mm_u        <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            if (capture) begin
                slot_digit[slot_idx] <= dec_digit;
                slot_valid[slot_idx] <= dec_valid;
                tmo_cnt              <= '0;
            end else if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (mask == 4'b1111) begin
                mask <= capture ? out_s : 4'b0000;
                if (frame_legal) begin
                    frame_valid <= 1'b1;
                    hh_t        <= slot_digit[HT][1:0];
                    hh_u        <= slot_digit[HU];
                    mm_t        <= slot_digit[MT][2:0];
                    mm_u        <= slot_digit[MU];
                end else begin
                    frame_err <= 1'b1;
                end
            end else if (capture) begin
                mask <= mask | out_s;
            end else if (scan_lost) begin
                mask <= '0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of scanned frames plus hand-built
// glitch, mid-frame reset and scan-loss sequences.
module tb_seg_scan_decoder;

    localparam int DWELL = 32;
    localparam int NV    = 12;

    typedef struct {
        logic [3:0][7:0] code;
        int              reps;
        int              exp_valid;
        int              exp_err;
        logic [12:0]     exp_time;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] out;
    logic [7:0] seg;
    logic [1:0] hh_t;
    logic [3:0] hh_u;
    logic [2:0] mm_t;
    logic [3:0] mm_u;
    logic       frame_valid;
    logic       frame_err;
    logic       scan_lost;

    int   vectors     = 0;
    int   miscompares = 0;
    int   valid_cnt   = 0;
    int   err_cnt     = 0;
    int   both_cnt    = 0;
    int   vb, eb, k;
    vec_t vecs [NV];

    seg_scan_decoder #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .out         (out),
        .seg         (seg),
        .hh_t        (hh_t),
        .hh_u        (hh_u),
        .mm_t        (mm_t),
        .mm_u        (mm_u),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .scan_lost   (scan_lost)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) valid_cnt++;
        if (frame_err) err_cnt++;
        if (frame_valid && frame_err) both_cnt++;
    end

    function automatic logic [7:0] seg_of(input int d);
        logic [6:0] p;
        case (d)
            0:       p = 7'b0000001;
            1:       p = 7'b1001111;
            2:       p = 7'b0010010;
            3:       p = 7'b0000110;
            4:       p = 7'b1001100;
            5:       p = 7'b0100100;
            6:       p = 7'b0100000;
            7:       p = 7'b0001111;
            8:       p = 7'b0000000;
            9:       p = 7'b0000100;
            14:      p = 7'b1111110;
            default: p = 7'b1111111;
        endcase
        return {p, 1'b1};
    endfunction

    function automatic logic [12:0] tm(input int a, input int b, input int c, input int d);
        return {2'(a), 4'(b), 3'(c), 4'(d)};
    endfunction

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input logic [3:0] dp_on, input int reps,
                                input int ev, input int ee, input logic [12:0] et);
        vec_t v;
        v.code[0]   = seg_of(a) & ~{7'b0, dp_on[0]};
        v.code[1]   = seg_of(b) & ~{7'b0, dp_on[1]};
        v.code[2]   = seg_of(c) & ~{7'b0, dp_on[2]};
        v.code[3]   = seg_of(d) & ~{7'b0, dp_on[3]};
        v.reps      = reps;
        v.exp_valid = ev;
        v.exp_err   = ee;
        v.exp_time  = et;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [15:0] actual,
                                input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] digit_en, input logic [7:0] code,
                                  input int dwell);
        out = digit_en;
        seg = code;
        repeat (dwell) @(negedge clk);
    endtask

    task automatic go_idle(input int cycles);
        out = 4'b0000;
        seg = 8'hFF;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic scan_frame(input logic [3:0][7:0] codes);
        for (int i = 0; i < 4; i++) apply_stimulus(4'(1 << i), codes[i], DWELL);
        go_idle(8);
    endtask

    function automatic logic [15:0] time_now();
        return {3'b000, hh_t, hh_u, mm_t, mm_u};
    endfunction

    initial begin
        //             HT  HU  MT  MU  dp      reps valid err expected time
        vecs[0]  = mk(2,  3,  5,  9,  4'b0000, 2,   2,    0,  tm(2, 3, 5, 9));
        vecs[1]  = mk(2,  4,  0,  0,  4'b0000, 1,   0,    1,  tm(2, 3, 5, 9));
        vecs[2]  = mk(1,  2,  3,  4,  4'b0000, 1,   1,    0,  tm(1, 2, 3, 4));
        vecs[3]  = mk(1,  2,  3,  15, 4'b0000, 1,   0,    1,  tm(1, 2, 3, 4));
        vecs[4]  = mk(1,  9,  0,  7,  4'b0010, 1,   1,    0,  tm(1, 9, 0, 7));
        vecs[5]  = mk(2,  0,  6,  0,  4'b0000, 1,   0,    1,  tm(1, 9, 0, 7));
        vecs[6]  = mk(0,  0,  0,  0,  4'b1111, 1,   1,    0,  tm(0, 0, 0, 0));
        vecs[7]  = mk(2,  9,  0,  0,  4'b0000, 1,   0,    1,  tm(0, 0, 0, 0));
        vecs[8]  = mk(3,  0,  0,  0,  4'b0000, 1,   0,    1,  tm(0, 0, 0, 0));
        vecs[9]  = mk(0,  9,  5,  9,  4'b0000, 1,   1,    0,  tm(0, 9, 5, 9));
        vecs[10] = mk(14, 1,  0,  0,  4'b0000, 1,   0,    1,  tm(0, 9, 5, 9));
        vecs[11] = mk(2,  0,  0,  5,  4'b0000, 1,   1,    0,  tm(2, 0, 0, 5));

        rst_n = 1'b0;
        out   = 4'b0000;
        seg   = 8'hFF;
        repeat (3) @(negedge clk);
        check_output("reset state",
                     {hh_t, hh_u, mm_t, mm_u, frame_valid, frame_err, scan_lost}, 16'h0000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < NV; r++) begin
            vb = valid_cnt;
            eb = err_cnt;
            for (int n = 0; n < vecs[r].reps; n++) scan_frame(vecs[r].code);
            check_output($sformatf("row%0d valid pulses", r), 16'(valid_cnt - vb),
                         16'(vecs[r].exp_valid));
            check_output($sformatf("row%0d err pulses", r), 16'(err_cnt - eb),
                         16'(vecs[r].exp_err));
            check_output($sformatf("row%0d time", r), time_now(), {3'b000, vecs[r].exp_time});
            check_output($sformatf("row%0d scan_lost", r), 16'(scan_lost), 16'h0000);
        end

        // 2-cycle glitch showing an 8 in the middle of the minutes-tens dwell
        vb = valid_cnt;
        eb = err_cnt;
        apply_stimulus(4'b0001, seg_of(1), DWELL);
        apply_stimulus(4'b0010, seg_of(2), DWELL);
        apply_stimulus(4'b0100, seg_of(3), 16);
        apply_stimulus(4'b0100, seg_of(8), 2);
        apply_stimulus(4'b0100, seg_of(3), 14);
        apply_stimulus(4'b1000, seg_of(4), DWELL);
        go_idle(8);
        check_output("glitch valid pulses", 16'(valid_cnt - vb), 16'd1);
        check_output("glitch err pulses", 16'(err_cnt - eb), 16'd0);
        check_output("glitch time", time_now(), {3'b000, tm(1, 2, 3, 4)});

        // Reset after two digits of 07:45, then a clean rescan
        apply_stimulus(4'b0001, seg_of(0), DWELL);
        apply_stimulus(4'b0010, seg_of(7), DWELL);
        out   = 4'b0000;
        rst_n = 1'b0;
        #1;
        check_output("mid-frame reset outputs",
                     {hh_t, hh_u, mm_t, mm_u, frame_valid, frame_err, scan_lost}, 16'h0000);
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vb = valid_cnt;
        eb = err_cnt;
        scan_frame({seg_of(5), seg_of(4), seg_of(7), seg_of(0)});
        check_output("rescan valid pulses", 16'(valid_cnt - vb), 16'd1);
        check_output("rescan err pulses", 16'(err_cnt - eb), 16'd0);
        check_output("rescan time", time_now(), {3'b000, tm(0, 7, 4, 5)});

        // Scan loss: the minutes-units value is sampled on the first posedge
        // after it is driven and captured 6 edges later; the counter then needs
        // 100 more edges, so scan_lost is first seen 107 negedges after driving.
        apply_stimulus(4'b0001, seg_of(1), DWELL);
        apply_stimulus(4'b0010, seg_of(8), DWELL);
        apply_stimulus(4'b0100, seg_of(3), DWELL);
        out = 4'b1000;
        seg = seg_of(2);
        k   = 0;
        for (int n = 1; n <= 250; n++) begin
            @(negedge clk);
            if (n == DWELL) go_idle(0);
            if (scan_lost) begin
                k = n;
                break;
            end
        end
        check_output("scan_lost rise delay", 16'(k), 16'd107);
        check_output("frame before loss", time_now(), {3'b000, tm(1, 8, 3, 2)});

        // The next capture lands on the 7th edge, so scan_lost is low from there
        out = 4'b0001;
        seg = seg_of(2);
        k   = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (!scan_lost) begin
                k = n;
                break;
            end
        end
        check_output("scan_lost fall delay", 16'(k), 16'd7);
        repeat (DWELL - k) @(negedge clk);
        go_idle(0);
        k = 0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (scan_lost) begin
                k = 1;
                break;
            end
        end
        check_output("scan_lost after lone digit", 16'(k), 16'd1);

        // The loss emptied the mask, so three digits alone must not complete a frame
        vb = valid_cnt;
        eb = err_cnt;
        apply_stimulus(4'b0010, seg_of(1), DWELL);
        apply_stimulus(4'b0100, seg_of(3), DWELL);
        apply_stimulus(4'b1000, seg_of(7), DWELL);
        go_idle(8);
        check_output("partial after loss valid", 16'(valid_cnt - vb), 16'd0);
        check_output("partial after loss err", 16'(err_cnt - eb), 16'd0);
        check_output("scan_lost cleared", 16'(scan_lost), 16'd0);
        apply_stimulus(4'b0001, seg_of(2), DWELL);
        go_idle(8);
        check_output("completed after loss valid", 16'(valid_cnt - vb), 16'd1);
        check_output("completed after loss time", time_now(), {3'b000, tm(2, 1, 3, 7)});

        check_output("valid/err exclusive", 16'(both_cnt), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
